// File: rtl/sfp_dot3_if.sv
// Handshake bundle for the sequential dot-product unit: operand vectors in, resized result out.
interface sfp_dot3_if #(
  parameter int IW = 8,
  parameter int QW = 8
);
  localparam int W = IW + QW;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_x, a_y, a_z;
  logic [W-1:0] b_x, b_y, b_z;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         clipping;

  modport master (
    output in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    input  in_ready, out_valid, out_data, clipping
  );

  modport slave (
    input  in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
    output in_ready, out_valid, out_data, clipping
  );
endinterface

// File: rtl/sfp_dot3.sv
// Signed IW.QW three-term dot product using one shared multiplier over three cycles,
// a 2W+2 bit accumulator and a floor/wrap-or-saturate resize back to IW.QW.
module sfp_dot3 #(
  parameter int IW   = 8,
  parameter int QW   = 8,
  parameter int CLIP = 0
) (
  input  logic       clk,
  input  logic       rst,
  sfp_dot3_if.slave  bus
);
  localparam int W  = IW + QW;
  localparam int AW = 2 * W + 2;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t               r_state, w_next;
  logic signed [W-1:0]  r_a [3];
  logic signed [W-1:0]  r_b [3];
  logic [1:0]           r_cnt;
  logic signed [AW-1:0] r_acc;
  logic [W-1:0]         r_out_data;
  logic                 r_clip;

  logic                 w_in_ready, w_out_valid, w_accept;
  logic signed [W-1:0]  w_a_sel, w_b_sel;
  logic signed [2*W-1:0] w_prod;
  logic signed [AW-1:0] w_sum, w_shift;
  logic                 w_fits, w_clip;
  logic [W-1:0]         w_res;

  assign w_accept = bus.in_valid & w_in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = MAC;
      MAC:  if (r_cnt == 2'd2) w_next = DONE;
      DONE: if (bus.out_ready) w_next = bus.in_valid ? MAC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // In DONE the unit can take new operands on the same edge the result retires.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: w_in_ready = 1'b1;
      DONE: begin
        w_in_ready  = bus.out_ready;
        w_out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_cnt)
      2'd0:    begin w_a_sel = r_a[0]; w_b_sel = r_b[0]; end
      2'd1:    begin w_a_sel = r_a[1]; w_b_sel = r_b[1]; end
      default: begin w_a_sel = r_a[2]; w_b_sel = r_b[2]; end
    endcase
  end

  assign w_prod = w_a_sel * w_b_sel;
  assign w_sum  = r_acc + {{2{w_prod[2*W-1]}}, w_prod};

  // Floor-shift to IW.QW scaling; the range check looks at every bit above the output sign.
  always_comb begin
    w_shift = w_sum >>> QW;
    w_fits  = (&w_shift[AW-1:W-1]) | ~(|w_shift[AW-1:W-1]);
    w_res   = w_shift[W-1:0];
    w_clip  = 1'b0;
    if (!w_fits) begin
      w_clip = 1'b1;
      if (CLIP != 0)
        w_res = w_shift[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

  // NOTE: the small operand file is reset explicitly because it is flop-based, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
      r_cnt      <= 2'd0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_clip     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a[0] <= bus.a_x;
        r_a[1] <= bus.a_y;
        r_a[2] <= bus.a_z;
        r_b[0] <= bus.b_x;
        r_b[1] <= bus.b_y;
        r_b[2] <= bus.b_z;
        r_cnt  <= 2'd0;
        r_acc  <= '0;
      end else if (r_state == MAC) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd2) begin
          r_out_data <= w_res;
          r_clip     <= w_clip;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.clipping  = r_clip;
endmodule

// File: tb/tb_sfp_dot3.sv
// Directed bench for sfp_dot3: a wrapping and a saturating instance driven in lockstep.
module tb_sfp_dot3;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sfp_dot3_if #(.IW(8), .QW(8)) bus_w ();
  sfp_dot3_if #(.IW(8), .QW(8)) bus_s ();

  sfp_dot3 #(.IW(8), .QW(8), .CLIP(0)) dut_wrap (.clk(clk), .rst(rst), .bus(bus_w.slave));
  sfp_dot3 #(.IW(8), .QW(8), .CLIP(1)) dut_sat  (.clk(clk), .rst(rst), .bus(bus_s.slave));

  task automatic set_ops(input logic [15:0] ax, ay, az, bx, by, bz);
    bus_w.a_x = ax; bus_w.a_y = ay; bus_w.a_z = az;
    bus_w.b_x = bx; bus_w.b_y = by; bus_w.b_z = bz;
    bus_s.a_x = ax; bus_s.a_y = ay; bus_s.a_z = az;
    bus_s.b_x = bx; bus_s.b_y = by; bus_s.b_z = bz;
  endtask

  task automatic set_in_valid(input logic v);
    bus_w.in_valid = v;
    bus_s.in_valid = v;
  endtask

  task automatic set_out_ready(input logic v);
    bus_w.out_ready = v;
    bus_s.out_ready = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold in_valid until the accepting edge; returns just after it.
  task automatic accept(input logic [15:0] ax, ay, az, bx, by, bz);
    int waited;
    set_ops(ax, ay, az, bx, by, bz);
    set_in_valid(1'b1);
    waited = 0;
    while (bus_w.in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (bus_w.in_ready !== 1'b1) begin
      $display("FAIL accept_timeout: in_ready=%b required 1", bus_w.in_ready);
      n_fail++;
    end
    tick();
    set_in_valid(1'b0);
  endtask

  // Counts edges after acceptance until out_valid is seen.
  task automatic wait_result(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_w.out_valid === 1'b1) begin
        edges = i;
        break;
      end
    end
    n_checks++;
    if (edges == 0) begin
      $display("FAIL result_timeout: out_valid never rose, required within 20 edges");
      n_fail++;
    end
  endtask

  task automatic retire();
    set_out_ready(1'b1);
    tick();
    set_out_ready(1'b0);
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus_w.in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b required 1", bus_w.in_ready); n_fail++;
    end
    n_checks++;
    if (bus_w.out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid: got %b required 0", bus_w.out_valid); n_fail++;
    end
    n_checks++;
    if (bus_w.out_data !== 16'h0000) begin
      $display("FAIL reset_out_data: got %h required 0000", bus_w.out_data); n_fail++;
    end
    n_checks++;
    if (bus_w.clipping !== 1'b0) begin
      $display("FAIL reset_clipping: got %b required 0", bus_w.clipping); n_fail++;
    end
  endtask

  task automatic test_basic();
    int edges;
    accept(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0080, 16'h0080);
    wait_result(edges);
    n_checks++;
    if (edges != 3) begin
      $display("FAIL basic_latency: got %0d edges required 3", edges); n_fail++;
    end
    n_checks++;
    if (bus_w.out_data !== 16'h0300) begin
      $display("FAIL basic_data: got %h required 0300", bus_w.out_data); n_fail++;
    end
    n_checks++;
    if (bus_w.clipping !== 1'b0) begin
      $display("FAIL basic_clipping: got %b required 0", bus_w.clipping); n_fail++;
    end
    n_checks++;
    if (bus_s.out_data !== 16'h0300) begin
      $display("FAIL basic_data_sat: got %h required 0300", bus_s.out_data); n_fail++;
    end
    retire();
  endtask

  task automatic test_sign();
    logic [15:0] ax_v [3];
    logic [15:0] bx_v [3];
    logic [15:0] exp_v [3];
    int edges;
    ax_v = '{16'hFE80, 16'h0001, 16'hFFFF};
    bx_v = '{16'h0040, 16'h0080, 16'h0080};
    exp_v = '{16'hFFA0, 16'h0000, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      accept(ax_v[i], 16'h0000, 16'h0000, bx_v[i], 16'h0000, 16'h0000);
      wait_result(edges);
      n_checks++;
      if (bus_w.out_data !== exp_v[i] || bus_w.clipping !== 1'b0) begin
        $display("FAIL sign_case%0d: got %h clip %b required %h clip 0",
                 i, bus_w.out_data, bus_w.clipping, exp_v[i]);
        n_fail++;
      end
      n_checks++;
      if (bus_s.out_data !== exp_v[i]) begin
        $display("FAIL sign_case%0d_sat: got %h required %h", i, bus_s.out_data, exp_v[i]);
        n_fail++;
      end
      retire();
    end
  endtask

  task automatic test_overflow();
    int edges;
    accept(16'h6400, 16'h6400, 16'h0000, 16'h0100, 16'h0100, 16'h0000);
    wait_result(edges);
    n_checks++;
    if (bus_w.out_data !== 16'hC800 || bus_w.clipping !== 1'b1) begin
      $display("FAIL ovf_pos_wrap: got %h clip %b required c800 clip 1",
               bus_w.out_data, bus_w.clipping); n_fail++;
    end
    n_checks++;
    if (bus_s.out_data !== 16'h7FFF || bus_s.clipping !== 1'b1) begin
      $display("FAIL ovf_pos_sat: got %h clip %b required 7fff clip 1",
               bus_s.out_data, bus_s.clipping); n_fail++;
    end
    retire();
    accept(16'h9C00, 16'h9C00, 16'h0000, 16'h0100, 16'h0100, 16'h0000);
    wait_result(edges);
    n_checks++;
    if (bus_w.out_data !== 16'h3800 || bus_w.clipping !== 1'b1) begin
      $display("FAIL ovf_neg_wrap: got %h clip %b required 3800 clip 1",
               bus_w.out_data, bus_w.clipping); n_fail++;
    end
    n_checks++;
    if (bus_s.out_data !== 16'h8000 || bus_s.clipping !== 1'b1) begin
      $display("FAIL ovf_neg_sat: got %h clip %b required 8000 clip 1",
               bus_s.out_data, bus_s.clipping); n_fail++;
    end
    retire();
  endtask

  task automatic test_backpressure();
    int edges;
    accept(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0080, 16'h0080);
    set_ops(16'h1234, 16'h5678, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h4321);
    wait_result(edges);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus_w.out_valid !== 1'b1 || bus_w.out_data !== 16'h0300 ||
          bus_w.clipping !== 1'b0 || bus_w.in_ready !== 1'b0) begin
        $display("FAIL bp_hold%0d: valid %b data %h clip %b in_ready %b required 1 0300 0 0",
                 i, bus_w.out_valid, bus_w.out_data, bus_w.clipping, bus_w.in_ready);
        n_fail++;
      end
      tick();
    end
    set_out_ready(1'b1);
    #1;
    n_checks++;
    if (bus_w.in_ready !== 1'b1) begin
      $display("FAIL bp_ready_comb: in_ready %b required 1", bus_w.in_ready); n_fail++;
    end
    tick();
    set_out_ready(1'b0);
    n_checks++;
    if (bus_w.out_valid !== 1'b0 || bus_w.in_ready !== 1'b1) begin
      $display("FAIL bp_release: valid %b in_ready %b required 0 1",
               bus_w.out_valid, bus_w.in_ready); n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    accept(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0080, 16'h0080);
    wait_result(edges);
    set_ops(16'hFE80, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000);
    set_in_valid(1'b1);
    set_out_ready(1'b1);
    #1;
    n_checks++;
    if (bus_w.in_ready !== 1'b1 || bus_w.out_data !== 16'h0300) begin
      $display("FAIL b2b_first: in_ready %b data %h required 1 0300",
               bus_w.in_ready, bus_w.out_data); n_fail++;
    end
    tick();
    set_in_valid(1'b0);
    set_out_ready(1'b0);
    n_checks++;
    if (bus_w.out_valid !== 1'b0 || bus_w.in_ready !== 1'b0) begin
      $display("FAIL b2b_into_mac: valid %b in_ready %b required 0 0",
               bus_w.out_valid, bus_w.in_ready); n_fail++;
    end
    wait_result(edges);
    n_checks++;
    if (edges != 3 || bus_w.out_data !== 16'hFFA0) begin
      $display("FAIL b2b_second: edges %0d data %h required 3 ffa0", edges, bus_w.out_data);
      n_fail++;
    end
    retire();
  endtask

  task automatic test_reset_mid();
    int edges;
    int seen;
    accept(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0080, 16'h0080);
    tick();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus_w.out_valid !== 1'b0) begin
      $display("FAIL rst_mid_valid: got %b required 0", bus_w.out_valid); n_fail++;
    end
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus_w.in_ready !== 1'b1) begin
      $display("FAIL rst_mid_ready: got %b required 1", bus_w.in_ready); n_fail++;
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus_w.out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      $display("FAIL rst_mid_stale: out_valid high on %0d cycles required 0", seen); n_fail++;
    end
    accept(16'h0100, 16'h0200, 16'h0300, 16'h0080, 16'h0080, 16'h0080);
    wait_result(edges);
    n_checks++;
    if (edges != 3 || bus_w.out_data !== 16'h0300) begin
      $display("FAIL rst_mid_after: edges %0d data %h required 3 0300", edges, bus_w.out_data);
      n_fail++;
    end
    retire();
  endtask

  initial begin
    rst = 1'b1;
    set_in_valid(1'b0);
    set_out_ready(1'b0);
    set_ops(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_sign();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
